issue_queue_dual: RTL and testbench

- Dual-slot instruction buffer and pairing unit between fetch and decode.
- Accepts up to two fetched instructions per cycle into a circular FIFO.
- Presents the oldest one or two entries to the decode stage as issue slots 0 and 1, which feed the decode-stage hazard/forwarding unit.
- Splits a pair whenever slot 1 cannot legally issue alongside slot 0, and holds its output while decode signals a load-use stall.

---
 rtl/issue_queue_dual_pkg.sv | 55 +++++
 rtl/issue_queue_dual_if.sv | 42 ++++
 rtl/issue_pair_check.sv | 34 +++
 rtl/issue_queue_dual.sv | 94 +++++++++
 tb/tb_issue_queue_dual.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_dual_pkg.sv
// Shared definitions for the dual-issue instruction queue: RV32 opcode constants,
// instruction field positions and register-usage classification.
package issue_queue_dual_pkg;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  // Highest instruction bit the pairing logic looks at (top of rs2).
  localparam int FIELD_MSB = 24;

  typedef logic [FIELD_MSB:0] fieldBits_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } instFields_t;

  function automatic instFields_t decodeFields(input fieldBits_t inst);
    instFields_t f;
    f.opcode = inst[6:0];
    f.rd     = inst[11:7];
    f.rs1    = inst[19:15];
    f.rs2    = inst[24:20];
    return f;
  endfunction

  function automatic logic usesRs1(input logic [6:0] opcode);
    return !(opcode == OPCODE_LUI || opcode == OPCODE_AUIPC || opcode == OPCODE_JAL);
  endfunction

  function automatic logic usesRs2(input logic [6:0] opcode);
    return opcode == OPCODE_BRANCH || opcode == OPCODE_STORE || opcode == OPCODE_OP;
  endfunction

  function automatic logic writesRd(input logic [6:0] opcode);
    return !(opcode == OPCODE_BRANCH || opcode == OPCODE_STORE);
  endfunction

  function automatic logic isMemOp(input logic [6:0] opcode);
    return opcode == OPCODE_LOAD || opcode == OPCODE_STORE;
  endfunction

  function automatic logic isControlOp(input logic [6:0] opcode);
    return opcode == OPCODE_BRANCH || opcode == OPCODE_JAL || opcode == OPCODE_JALR;
  endfunction

endpackage

// File: rtl/issue_queue_dual_if.sv
// Fetch-to-queue and queue-to-decode signalling of the dual-issue queue.
// The master side is the fetch/decode pipeline; the slave side is the queue.
interface issue_queue_dual_if #(
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int PTR_WIDTH  = 3
);
  logic                  Fetch_InstValid_0;
  logic [INST_WIDTH-1:0] Fetch_Inst_0;
  logic [PC_WIDTH-1:0]   Fetch_Pc_0;
  logic                  Fetch_InstValid_1;
  logic [INST_WIDTH-1:0] Fetch_Inst_1;
  logic [PC_WIDTH-1:0]   Fetch_Pc_1;
  logic                  IQ_FetchReady;
  logic                  DecodeHazard_StallReq;
  logic                  Branch_Flush;
  logic                  IQ_Valid_0;
  logic [INST_WIDTH-1:0] IQ_Inst_0;
  logic [PC_WIDTH-1:0]   IQ_Pc_0;
  logic                  IQ_Valid_1;
  logic [INST_WIDTH-1:0] IQ_Inst_1;
  logic [PC_WIDTH-1:0]   IQ_Pc_1;
  logic [PTR_WIDTH:0]    IQ_Count;

  modport master (
    output Fetch_InstValid_0, Fetch_Inst_0, Fetch_Pc_0,
    output Fetch_InstValid_1, Fetch_Inst_1, Fetch_Pc_1,
    output DecodeHazard_StallReq, Branch_Flush,
    input  IQ_FetchReady, IQ_Count,
    input  IQ_Valid_0, IQ_Inst_0, IQ_Pc_0,
    input  IQ_Valid_1, IQ_Inst_1, IQ_Pc_1
  );

  modport slave (
    input  Fetch_InstValid_0, Fetch_Inst_0, Fetch_Pc_0,
    input  Fetch_InstValid_1, Fetch_Inst_1, Fetch_Pc_1,
    input  DecodeHazard_StallReq, Branch_Flush,
    output IQ_FetchReady, IQ_Count,
    output IQ_Valid_0, IQ_Inst_0, IQ_Pc_0,
    output IQ_Valid_1, IQ_Inst_1, IQ_Pc_1
  );
endinterface

// File: rtl/issue_pair_check.sv
// Decides whether the second-oldest instruction may issue in the same cycle as
// the oldest one: blocks RAW dependences, pairing behind control flow, and two memory ops.
module issue_pair_check
  import issue_queue_dual_pkg::*;
(
  input  fieldBits_t slot0Inst,
  input  fieldBits_t slot1Inst,
  output logic       pairOk
);

  instFields_t f0;
  instFields_t f1;
  logic        rawHazard;
  logic        controlHazard;
  logic        memHazard;

  assign f0 = decodeFields(slot0Inst);
  assign f1 = decodeFields(slot1Inst);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rawHazard = 1'b0;
    if (writesRd(f0.opcode) && (f0.rd != 5'd0)) begin
      if (usesRs1(f1.opcode) && (f1.rs1 == f0.rd)) rawHazard = 1'b1;
      if (usesRs2(f1.opcode) && (f1.rs2 == f0.rd)) rawHazard = 1'b1;
    end
  end

  // WAW pairs are allowed: decode forwarding already prefers slot 1.
  assign controlHazard = isControlOp(f0.opcode);
  assign memHazard     = isMemOp(f0.opcode) && isMemOp(f1.opcode);
  assign pairOk        = !(rawHazard || controlHazard || memHazard);

endmodule

// File: rtl/issue_queue_dual.sv
// Dual-slot circular instruction queue between fetch and decode: takes up to two
// instructions per cycle and presents the oldest one or two as show-ahead issue slots.
module issue_queue_dual
  import issue_queue_dual_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  issue_queue_dual_if.slave  iq
);

  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [PTR_WIDTH:0]   cnt_t;

  // Ready only with room for a full pair, so a two-wide push can never overflow.
  localparam cnt_t READY_LIMIT = cnt_t'(DEPTH - 2);

  ptr_t                  headPtr;
  ptr_t                  tailPtr;
  cnt_t                  count;
  logic [INST_WIDTH-1:0] entryInst [DEPTH];
  logic [PC_WIDTH-1:0]   entryPc   [DEPTH];

  logic fetchReady;
  logic enqEn;
  logic pairOk;
  logic issueValid0;
  logic issueValid1;
  logic [1:0] enqNum;
  logic [1:0] deqNum;
  ptr_t headPlus1;
  ptr_t slot1WrPtr;

  assign fetchReady = (count <= READY_LIMIT);
  assign enqEn      = fetchReady && !iq.Branch_Flush;
  assign enqNum     = enqEn ? (2'(iq.Fetch_InstValid_0) + 2'(iq.Fetch_InstValid_1)) : 2'd0;
  // A lone slot-1 instruction lands at tail so the queue stays dense.
  assign slot1WrPtr = iq.Fetch_InstValid_0 ? (tailPtr + ptr_t'(1)) : tailPtr;
  assign headPlus1  = headPtr + ptr_t'(1);

  issue_pair_check u_pairCheck (
    .slot0Inst (entryInst[headPtr][FIELD_MSB:0]),
    .slot1Inst (entryInst[headPlus1][FIELD_MSB:0]),
    .pairOk    (pairOk)
  );

  assign issueValid0 = (count != '0) && !iq.Branch_Flush;
  assign issueValid1 = (count >= cnt_t'(2)) && pairOk && !iq.Branch_Flush;
  assign deqNum      = iq.DecodeHazard_StallReq ? 2'd0
                                                : (2'(issueValid0) + 2'(issueValid1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else if (iq.Branch_Flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      headPtr <= headPtr + ptr_t'(deqNum);
      tailPtr <= tailPtr + ptr_t'(enqNum);
      count   <= count + cnt_t'(enqNum) - cnt_t'(deqNum);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (enqEn && iq.Fetch_InstValid_0) begin
      entryInst[tailPtr] <= iq.Fetch_Inst_0;
      entryPc[tailPtr]   <= iq.Fetch_Pc_0;
    end
    if (enqEn && iq.Fetch_InstValid_1) begin
      entryInst[slot1WrPtr] <= iq.Fetch_Inst_1;
      entryPc[slot1WrPtr]   <= iq.Fetch_Pc_1;
    end
  end

  assign iq.IQ_FetchReady = fetchReady;
  assign iq.IQ_Count      = count;
  assign iq.IQ_Valid_0    = issueValid0;
  assign iq.IQ_Inst_0     = entryInst[headPtr];
  assign iq.IQ_Pc_0       = entryPc[headPtr];
  assign iq.IQ_Valid_1    = issueValid1;
  assign iq.IQ_Inst_1     = entryInst[headPlus1];
  assign iq.IQ_Pc_1       = entryPc[headPlus1];

endmodule

// File: tb/tb_issue_queue_dual.sv
// Self-checking bench for issue_queue_dual: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the issue/pairing rules.
module tb_issue_queue_dual;

  localparam int DEPTH      = 8;
  localparam int PTR_WIDTH  = 3;
  localparam int INST_WIDTH = 32;
  localparam int PC_WIDTH   = 32;

  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  typedef struct packed {
    logic        v0;
    logic        v1;
    logic        rdy;
    logic [3:0]  cnt;
    logic [31:0] inst0;
    logic [31:0] pc0;
    logic [31:0] inst1;
    logic [31:0] pc1;
  } view_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] pcSeq = 32'h0000_1000;
  entry_t refQ[$];

  always #5 clk = ~clk;

  issue_queue_dual_if #(.INST_WIDTH(INST_WIDTH), .PC_WIDTH(PC_WIDTH), .PTR_WIDTH(PTR_WIDTH)) iq ();

  issue_queue_dual #(
    .DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH), .INST_WIDTH(INST_WIDTH), .PC_WIDTH(PC_WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iq    (iq)
  );

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(logic [6:0] op, int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(int rd, int rs1, int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), OP_OP};
  endfunction
  function automatic logic [31:0] enc_s(logic [6:0] op, int rs1, int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b010, 5'b0, op};
  endfunction
  function automatic logic [31:0] enc_u(logic [6:0] op, int rd);
    return {20'h12345, 5'(rd), op};
  endfunction

  function automatic logic [31:0] rand_inst();
    int rd  = $urandom_range(0, 7);
    int rs1 = $urandom_range(0, 7);
    int rs2 = $urandom_range(0, 7);
    case ($urandom_range(0, 8))
      0:       return enc_i(OP_IMM, rd, rs1, $urandom_range(0, 100));
      1:       return enc_r(rd, rs1, rs2);
      2:       return enc_i(OP_LD, rd, rs1, 4);
      3:       return enc_s(OP_ST, rs1, rs2);
      4:       return enc_s(OP_BR, rs1, rs2);
      5:       return enc_u(OP_JAL, rd);
      6:       return enc_i(OP_JALR, rd, rs1, 0);
      7:       return enc_u(OP_LUI, rd);
      default: return enc_u(OP_AUIPC, rd);
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic bit ref_pair_ok(logic [31:0] a, logic [31:0] b);
    logic [6:0] opA = a[6:0];
    logic [6:0] opB = b[6:0];
    int rdA = int'(a[11:7]);
    int srcB[$];
    if (opA inside {OP_BR, OP_JAL, OP_JALR}) return 1'b0;
    if ((opA inside {OP_LD, OP_ST}) && (opB inside {OP_LD, OP_ST})) return 1'b0;
    if (!(opB inside {OP_LUI, OP_AUIPC, OP_JAL})) srcB.push_back(int'(b[19:15]));
    if (opB inside {OP_BR, OP_ST, OP_OP}) srcB.push_back(int'(b[24:20]));
    if (!(opA inside {OP_BR, OP_ST}) && rdA != 0)
      foreach (srcB[k]) if (srcB[k] == rdA) return 1'b0;
    return 1'b1;
  endfunction

  function automatic view_t model_view();
    view_t e = '0;
    int n = refQ.size();
    e.cnt = 4'(n);
    e.rdy = (n <= DEPTH - 2);
    if (n >= 1) begin
      e.v0 = !iq.Branch_Flush;
      e.inst0 = refQ[0].inst;
      e.pc0 = refQ[0].pc;
    end
    if (n >= 2) begin
      e.v1 = !iq.Branch_Flush && ref_pair_ok(refQ[0].inst, refQ[1].inst);
      e.inst1 = refQ[1].inst;
      e.pc1 = refQ[1].pc;
    end
    return e;
  endfunction

  function automatic view_t sample();
    view_t o;
    o.v0 = iq.IQ_Valid_0;   o.v1 = iq.IQ_Valid_1;
    o.rdy = iq.IQ_FetchReady; o.cnt = iq.IQ_Count;
    o.inst0 = iq.IQ_Inst_0; o.pc0 = iq.IQ_Pc_0;
    o.inst1 = iq.IQ_Inst_1; o.pc1 = iq.IQ_Pc_1;
    return o;
  endfunction

  // Slot contents are don't-care when the slot is not valid.
  function automatic view_t masked(view_t v);
    view_t m = v;
    if (m.v0 !== 1'b1) begin m.inst0 = '0; m.pc0 = '0; end
    if (m.v1 !== 1'b1) begin m.inst1 = '0; m.pc1 = '0; end
    return m;
  endfunction

  function automatic string fmt(view_t v);
    return $sformatf("v0=%b v1=%b rdy=%b cnt=%0d i0=%h pc0=%h i1=%h pc1=%h",
                     v.v0, v.v1, v.rdy, v.cnt, v.inst0, v.pc0, v.inst1, v.pc1);
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic drive(bit v0, logic [31:0] i0, bit v1, logic [31:0] i1, bit stall, bit flush);
    iq.Fetch_InstValid_0 = v0; iq.Fetch_Inst_0 = i0; iq.Fetch_Pc_0 = pcSeq;
    iq.Fetch_InstValid_1 = v1; iq.Fetch_Inst_1 = i1; iq.Fetch_Pc_1 = pcSeq + 32'd4;
    iq.DecodeHazard_StallReq = stall;
    iq.Branch_Flush = flush;
    pcSeq = pcSeq + 32'd8;
    #1;
  endtask

  task automatic idle(bit stall);
    drive(1'b0, 32'h0, 1'b0, 32'h0, stall, 1'b0);
  endtask

  // Advances one clock and applies the same edge to the reference model.
  task automatic tick();
    view_t e = model_view();
    int deq;
    @(posedge clk);
    if (!rst_n || iq.Branch_Flush) begin
      refQ.delete();
    end else begin
      deq = iq.DecodeHazard_StallReq ? 0 : int'(e.v0) + int'(e.v1);
      repeat (deq) void'(refQ.pop_front());
      if (e.rdy) begin
        if (iq.Fetch_InstValid_0) refQ.push_back('{inst: iq.Fetch_Inst_0, pc: iq.Fetch_Pc_0});
        if (iq.Fetch_InstValid_1) refQ.push_back('{inst: iq.Fetch_Inst_1, pc: iq.Fetch_Pc_1});
      end
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    view_t o;
    rst_n = 1'b0;
    drive(1'b1, enc_i(OP_IMM, 1, 0, 1), 1'b1, enc_i(OP_IMM, 2, 0, 2), 1'b0, 1'b1);
    repeat (2) tick();
    rst_n = 1'b1;
    idle(1'b0);
    o = sample();
    compared++;
    if ({o.v0, o.v1, o.rdy, o.cnt} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
      mismatched++;
      $display("FAIL reset_state: got %s want v0=0 v1=0 rdy=1 cnt=0", fmt(o));
    end
  endtask

  task automatic test_pair_independent();
    view_t o, e;
    logic [31:0] a = enc_i(OP_IMM, 1, 0, 1);
    logic [31:0] b = enc_i(OP_IMM, 2, 0, 2);
    drive(1'b1, a, 1'b1, b, 1'b0, 1'b0);
    o = sample();
    compared++;
    if (o.v0 !== 1'b0) begin
      mismatched++;
      $display("FAIL no_bypass: got v0=%b want 0", o.v0);
    end
    tick();
    idle(1'b0);
    o = sample(); e = model_view();
    compared++;
    if ({o.v0, o.v1, o.cnt, o.inst0, o.inst1} !== {1'b1, 1'b1, 4'd2, a, b} || masked(o) !== masked(e)) begin
      mismatched++;
      $display("FAIL indep_pair: got %s want %s", fmt(o), fmt(e));
    end
    tick();
    o = sample();
    compared++;
    if ({o.v0, o.cnt} !== {1'b0, 4'd0}) begin
      mismatched++;
      $display("FAIL indep_drain: got v0=%b cnt=%0d want v0=0 cnt=0", o.v0, o.cnt);
    end
  endtask

  task automatic test_raw();
    view_t o, e;
    logic [31:0] a = enc_i(OP_IMM, 5, 0, 1);
    logic [31:0] b = enc_r(6, 5, 5);
    drive(1'b1, a, 1'b1, b, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    o = sample(); e = model_view();
    compared++;
    if ({o.v0, o.v1, o.cnt} !== {1'b1, 1'b0, 4'd2} || masked(o) !== masked(e)) begin
      mismatched++;
      $display("FAIL raw_split: got %s want %s", fmt(o), fmt(e));
    end
    tick();
    o = sample();
    compared++;
    if ({o.v0, o.v1, o.cnt, o.inst0} !== {1'b1, 1'b0, 4'd1, b}) begin
      mismatched++;
      $display("FAIL raw_second: got %s want v0=1 v1=0 cnt=1 i0=%h", fmt(o), b);
    end
    tick();
    // Destination x0 carries no dependence.
    a = enc_i(OP_IMM, 0, 0, 1);
    b = enc_r(6, 0, 0);
    drive(1'b1, a, 1'b1, b, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    o = sample();
    compared++;
    if ({o.v0, o.v1, o.inst1} !== {1'b1, 1'b1, b}) begin
      mismatched++;
      $display("FAIL raw_x0_pair: got %s want v0=1 v1=1 i1=%h", fmt(o), b);
    end
    tick();
  endtask

  task automatic test_ctrl_mem();
    view_t o, e;
    logic [31:0] t0[6];
    logic [31:0] t1[6];
    bit expV1[6];
    t0[0] = enc_s(OP_BR, 1, 2);      t1[0] = enc_r(3, 4, 5);         expV1[0] = 1'b0;
    t0[1] = enc_i(OP_LD, 3, 1, 0);   t1[1] = enc_s(OP_ST, 2, 4);     expV1[1] = 1'b0;
    t0[2] = enc_i(OP_LD, 3, 1, 0);   t1[2] = enc_r(4, 1, 2);         expV1[2] = 1'b1;
    t0[3] = enc_u(OP_JAL, 1);        t1[3] = enc_i(OP_IMM, 2, 0, 0); expV1[3] = 1'b0;
    t0[4] = enc_r(7, 1, 2);          t1[4] = enc_s(OP_ST, 3, 7);     expV1[4] = 1'b0;
    t0[5] = enc_u(OP_LUI, 7);        t1[5] = enc_u(OP_AUIPC, 7);     expV1[5] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, t0[k], 1'b1, t1[k], 1'b0, 1'b0);
      tick();
      idle(1'b0);
      o = sample(); e = model_view();
      compared++;
      if (o.v1 !== expV1[k] || masked(o) !== masked(e)) begin
        mismatched++;
        $display("FAIL ctrl_mem_%0d: got %s want v1=%b model %s", k, fmt(o), expV1[k], fmt(e));
      end
      for (int g = 0; g < 3 && refQ.size() > 0; g++) tick();
    end
  endtask

  task automatic test_fill_wrap();
    view_t o, e;
    int expCnt[4] = '{7, 5, 3, 1};
    drive(1'b1, enc_i(OP_IMM, 10, 0, 0), 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, enc_i(OP_IMM, 11 + k, 0, k), 1'b1, enc_i(OP_IMM, 20 + k, 0, k), 1'b1, 1'b0);
      o = sample(); e = model_view();
      compared++;
      if (masked(o) !== masked(e)) begin
        mismatched++;
        $display("FAIL fill_%0d: got %s want %s", k, fmt(o), fmt(e));
      end
      tick();
    end
    // Full: fetch keeps presenting a pair that must be ignored.
    drive(1'b1, enc_i(OP_IMM, 30, 0, 0), 1'b1, enc_i(OP_IMM, 31, 0, 0), 1'b1, 1'b0);
    o = sample();
    compared++;
    if ({o.rdy, o.cnt} !== {1'b0, 4'd7}) begin
      mismatched++;
      $display("FAIL fill_full: got rdy=%b cnt=%0d want rdy=0 cnt=7", o.rdy, o.cnt);
    end
    tick();
    idle(1'b0);
    for (int k = 0; k < 4; k++) begin
      o = sample(); e = model_view();
      compared++;
      if (o.cnt !== 4'(expCnt[k]) || masked(o) !== masked(e)) begin
        mismatched++;
        $display("FAIL drain_%0d: got %s want cnt=%0d model %s", k, fmt(o), expCnt[k], fmt(e));
      end
      tick();
    end
    o = sample();
    compared++;
    if ({o.v0, o.cnt} !== {1'b0, 4'd0}) begin
      mismatched++;
      $display("FAIL drain_empty: got v0=%b cnt=%0d want v0=0 cnt=0", o.v0, o.cnt);
    end
  endtask

  task automatic test_stall();
    view_t o, e;
    logic [31:0] ins[4];
    for (int k = 0; k < 4; k++) ins[k] = enc_i(OP_IMM, 12 + k, 0, 7 * k);
    drive(1'b1, ins[0], 1'b1, ins[1], 1'b1, 1'b0);
    tick();
    drive(1'b1, ins[2], 1'b1, ins[3], 1'b1, 1'b0);
    tick();
    idle(1'b1);
    for (int k = 0; k < 3; k++) begin
      o = sample(); e = model_view();
      compared++;
      if ({o.v0, o.v1, o.cnt, o.inst0, o.inst1} !== {1'b1, 1'b1, 4'd4, ins[0], ins[1]}
          || masked(o) !== masked(e)) begin
        mismatched++;
        $display("FAIL stall_hold_%0d: got %s want %s", k, fmt(o), fmt(e));
      end
      tick();
    end
    idle(1'b0);
    tick();
    o = sample();
    compared++;
    if ({o.cnt, o.inst0, o.inst1} !== {4'd2, ins[2], ins[3]}) begin
      mismatched++;
      $display("FAIL stall_release: got %s want cnt=2 i0=%h i1=%h", fmt(o), ins[2], ins[3]);
    end
    tick();
  endtask

  task automatic test_flush();
    view_t o;
    drive(1'b1, enc_i(OP_IMM, 1, 0, 1), 1'b1, enc_i(OP_IMM, 2, 0, 2), 1'b1, 1'b0);
    tick();
    drive(1'b1, enc_i(OP_IMM, 3, 0, 3), 1'b1, enc_i(OP_IMM, 4, 0, 4), 1'b1, 1'b0);
    tick();
    drive(1'b1, enc_i(OP_IMM, 5, 0, 5), 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, enc_i(OP_IMM, 6, 0, 6), 1'b1, enc_i(OP_IMM, 7, 0, 7), 1'b1, 1'b1);
    o = sample();
    compared++;
    if ({o.v0, o.v1, o.cnt} !== {1'b0, 1'b0, 4'd5}) begin
      mismatched++;
      $display("FAIL flush_cycle: got %s want v0=0 v1=0 cnt=5", fmt(o));
    end
    tick();
    idle(1'b0);
    o = sample();
    compared++;
    if ({o.v0, o.rdy, o.cnt} !== {1'b0, 1'b1, 4'd0}) begin
      mismatched++;
      $display("FAIL flush_after: got %s want v0=0 rdy=1 cnt=0", fmt(o));
    end
  endtask

  task automatic test_random();
    view_t o, e;
    int shown = 0;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 7, rand_inst(), $urandom_range(0, 9) < 7, rand_inst(),
            $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0);
      o = sample(); e = model_view();
      compared++;
      if (masked(o) !== masked(e)) begin
        mismatched++;
        if (shown < 10) $display("FAIL random_c%0d: got %s want %s", c, fmt(o), fmt(e));
        shown++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_pair_independent();
    test_raw();
    test_ctrl_mem();
    test_fill_wrap();
    test_stall();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
